// File: rtl/vga_compositor_param_if.sv
// PicoBlaze output-port bus carrying register writes into the VGA compositor.
interface vga_compositor_param_if;
   logic [7:0] port_id;
   logic [7:0] in_dato;
   logic       write_strobe;

   modport master (output port_id, output in_dato, output write_strobe);
   modport slave  (input  port_id, input  in_dato, input  write_strobe);
endinterface

// File: rtl/vga_compositor_param.sv
// VGA timing generator with a priority-ordered layer compositor and PicoBlaze control registers.
// Optional macro VGA_COMP_FRAME_SYNC_EN: layer_en/blink_sel/blink_rate are shadowed and applied at frame start.
module vga_compositor_param #(
   parameter int         NUM_LAYERS = 6,
   parameter int         RGB_W      = 8,
   parameter int         CLK_DIV    = 4,
   parameter int         H_VIS      = 640,
   parameter int         H_FP       = 16,
   parameter int         H_SYNC     = 96,
   parameter int         H_BP       = 48,
   parameter int         V_VIS      = 480,
   parameter int         V_FP       = 10,
   parameter int         V_SYNC     = 2,
   parameter int         V_BP       = 33,
   parameter int         BLINK_SLOW = 24999999,
   parameter int         BLINK_FAST = 16666666,
   parameter logic [7:0] PORT_BASE  = 8'h40
) (
   input  logic                        clock,
   input  logic                        reset,
   vga_compositor_param_if.slave       pb,
   input  logic [NUM_LAYERS-1:0]       layer_on,
   input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
   output logic [9:0]                  pixel_x,
   output logic [9:0]                  pixel_y,
   output logic                        pixel_tick,
   output logic                        video_on,
   output logic                        frame_start,
   output logic                        hsync,
   output logic                        vsync,
   output logic [RGB_W-1:0]            RGB
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BS_W  = (BLINK_SLOW > 0) ? $clog2(BLINK_SLOW + 1) : 1;
   localparam int BF_W  = (BLINK_FAST > 0) ? $clog2(BLINK_FAST + 1) : 1;
   localparam int BG_W  = (RGB_W < 8) ? RGB_W : 8;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BS_W-1:0]  SLOW_LAST = BS_W'(BLINK_SLOW);
   localparam logic [BF_W-1:0]  FAST_LAST = BF_W'(BLINK_FAST);
   localparam logic [9:0]       H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]       V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]       H_VIS_L   = 10'(H_VIS);
   localparam logic [9:0]       V_VIS_L   = 10'(V_VIS);
   localparam logic [9:0]       HS_START  = 10'(H_VIS + H_FP);
   localparam logic [9:0]       HS_END    = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]       VS_START  = 10'(V_VIS + V_FP);
   localparam logic [9:0]       VS_END    = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [7:0]       A_EN      = PORT_BASE;
   localparam logic [7:0]       A_SEL     = PORT_BASE + 8'd1;
   localparam logic [7:0]       A_RATE    = PORT_BASE + 8'd2;
   localparam logic [7:0]       A_BG      = PORT_BASE + 8'd3;

   logic [DIV_W-1:0]      div_q, div_d;
   logic [9:0]            x_q, x_d, y_q, y_d;
   logic [NUM_LAYERS-1:0] en_q, sel_q, rate_q;
   logic [BG_W-1:0]       bg_q;
   logic [BS_W-1:0]       slow_cnt_q;
   logic [BF_W-1:0]       fast_cnt_q;
   logic                  blink_slow_q, blink_fast_q;
   logic [NUM_LAYERS-1:0] use_en, use_sel, use_rate, blink_vec, eligible;
   logic [RGB_W-1:0]      bg_rgb, rgb_d, rgb_q;
   logic                  hs_raw, vs_raw, hs_q, vs_q;

   // Stage 0: pixel strobe and raster position
   assign pixel_tick  = (div_q == DIV_LAST);
   assign frame_start = pixel_tick && (x_q == 10'd0) && (y_q == 10'd0);
   assign video_on    = (x_q < H_VIS_L) && (y_q < V_VIS_L);
   assign hs_raw      = !((x_q >= HS_START) && (x_q < HS_END));
   assign vs_raw      = !((y_q >= VS_START) && (y_q < VS_END));

   always_comb begin
      div_d = pixel_tick ? '0 : div_q + DIV_W'(1);
      x_d   = x_q;
      y_d   = y_q;
      if (pixel_tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   // Register bits above NUM_LAYERS (or above RGB_W for the background) are simply not stored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q   <= '1;
         sel_q  <= '0;
         rate_q <= '0;
         bg_q   <= '0;
      end else if (pb.write_strobe) begin
         if (pb.port_id == A_EN)   en_q   <= pb.in_dato[NUM_LAYERS-1:0];
         if (pb.port_id == A_SEL)  sel_q  <= pb.in_dato[NUM_LAYERS-1:0];
         if (pb.port_id == A_RATE) rate_q <= pb.in_dato[NUM_LAYERS-1:0];
         if (pb.port_id == A_BG)   bg_q   <= pb.in_dato[BG_W-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slow_cnt_q   <= '0;
         fast_cnt_q   <= '0;
         blink_slow_q <= 1'b0;
         blink_fast_q <= 1'b0;
      end else begin
         if (slow_cnt_q == SLOW_LAST) begin
            slow_cnt_q   <= '0;
            blink_slow_q <= ~blink_slow_q;
         end else begin
            slow_cnt_q <= slow_cnt_q + BS_W'(1);
         end
         if (fast_cnt_q == FAST_LAST) begin
            fast_cnt_q   <= '0;
            blink_fast_q <= ~blink_fast_q;
         end else begin
            fast_cnt_q <= fast_cnt_q + BF_W'(1);
         end
      end
   end

`ifdef VGA_COMP_FRAME_SYNC_EN
   logic [NUM_LAYERS-1:0] en_sh_q, sel_sh_q, rate_sh_q;

   // Loading on the frame_start edge captures the pre-write value of a coincident write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_sh_q   <= '1;
         sel_sh_q  <= '0;
         rate_sh_q <= '0;
      end else if (frame_start) begin
         en_sh_q   <= en_q;
         sel_sh_q  <= sel_q;
         rate_sh_q <= rate_q;
      end
   end

   assign use_en   = en_sh_q;
   assign use_sel  = sel_sh_q;
   assign use_rate = rate_sh_q;
`else
   assign use_en   = en_q;
   assign use_sel  = sel_q;
   assign use_rate = rate_q;
`endif

   assign blink_vec = (use_rate & {NUM_LAYERS{blink_fast_q}}) | (~use_rate & {NUM_LAYERS{blink_slow_q}});
   assign eligible  = layer_on & use_en & (~use_sel | blink_vec);
   assign bg_rgb    = RGB_W'(bg_q);

   // Descending scan so the lowest-index eligible layer wins.
   always_comb begin
      rgb_d = bg_rgb;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (eligible[k]) rgb_d = layer_rgb[k*RGB_W +: RGB_W];
      end
      if (!video_on) rgb_d = '0;
   end

   // Stage 1: colour and syncs registered together to stay aligned
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else if (pixel_tick) begin
         rgb_q <= rgb_d;
         hs_q  <= hs_raw;
         vs_q  <= vs_raw;
      end
   end

   assign pixel_x = x_q;
   assign pixel_y = y_q;
   assign hsync   = hs_q;
   assign vsync   = vs_q;
   assign RGB     = rgb_q;
endmodule

// File: doc/vga_compositor_param.md
VGA_COMPOSITOR_PARAM -- requirements
Module: vga_compositor_param

Interface
REQ-001 Parameter NUM_LAYERS, default 6, number of priority-ordered pixel layers; legal range 1..8; layer 0 has highest priority.
REQ-002 Parameter RGB_W, default 8, width of each layer colour and of RGB.
REQ-003 Parameter CLK_DIV, default 4, number of clock cycles per pixel_tick.
REQ-004 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-005 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-006 Parameters BLINK_SLOW and BLINK_FAST, defaults 24999999 and 16666666, terminal counts of the two blink dividers.
REQ-007 Parameter PORT_BASE, default 8'h40, base port_id of the register block.
REQ-008 clock  input  1  system clock.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 port_id  input  8  PicoBlaze port address.
REQ-011 in_dato  input  8  PicoBlaze write data.
REQ-012 write_strobe  input  1  PicoBlaze write qualifier, one clock wide.
REQ-013 layer_on  input  NUM_LAYERS  per-layer pixel coverage for the current pixel_x/pixel_y.
REQ-014 layer_rgb  input  NUM_LAYERS*RGB_W  per-layer colour; layer k occupies bits [k*RGB_W +: RGB_W].
REQ-015 pixel_x, pixel_y  output  10 each  current pixel coordinates.
REQ-016 pixel_tick, video_on, frame_start  output  1 each  pixel strobe, visible region, and one-pixel_tick pulse at x=0, y=0.
REQ-017 hsync, vsync  output  1 each  active-low syncs, aligned with RGB.
REQ-018 RGB  output  RGB_W  composited pixel colour.

Function
REQ-019 pixel_tick SHALL assert for one clock every CLK_DIV clocks; all counters and RGB update only on clocks with pixel_tick high.
REQ-020 pixel_x SHALL count 0..H_VIS+H_FP+H_SYNC+H_BP-1, then wrap to 0 and increment pixel_y; pixel_y SHALL wrap to 0 after V_VIS+V_FP+V_SYNC+V_BP-1.
REQ-021 video_on SHALL be high iff pixel_x<H_VIS and pixel_y<V_VIS; raw hsync SHALL be low for pixel_x in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); vsync likewise for pixel_y.
REQ-022 Registers: PORT_BASE+0 layer_en, PORT_BASE+1 blink_sel, PORT_BASE+2 blink_rate (0=slow, 1=fast), PORT_BASE+3 bg_color; each bit k applies to layer k; bits k>=NUM_LAYERS SHALL be ignored.
REQ-023 A register SHALL load in_dato on the clock where write_strobe=1 and port_id matches its address; writes to any other port_id SHALL be ignored.
REQ-024 Two free-running dividers SHALL toggle blink_slow and blink_fast when reaching BLINK_SLOW and BLINK_FAST respectively, then wrap to 0.
REQ-025 Layer k is eligible iff layer_on[k] & en[k] & (~sel[k] | (rate[k] ? blink_fast : blink_slow)).
REQ-026 RGB_next SHALL equal 0 when video_on=0, otherwise the colour of the lowest-index eligible layer, otherwise bg_color[RGB_W-1:0].
REQ-027 RGB SHALL register RGB_next on pixel_tick (latency: one pixel_tick); hsync and vsync SHALL be delayed by the same one pixel_tick so that they stay aligned with RGB.

Reset
REQ-028 On reset: counters, pixel_x, pixel_y = 0; RGB = 0; hsync = vsync = 1; layer_en = all ones; blink_sel, blink_rate, bg_color = 0; blink_slow = blink_fast = 0.
REQ-029 Reset asserted mid-frame SHALL return all state to its REQ-028 value immediately; frame_start SHALL pulse on the first pixel_tick after release.

Configuration
REQ-030 Macro VGA_COMP_FRAME_SYNC_EN defined: layer_en, blink_sel and blink_rate SHALL be used through shadow copies that load from the written registers only on the frame_start pixel_tick; a write and a frame_start in the same clock SHALL shadow the pre-write value.
REQ-031 Macro VGA_COMP_FRAME_SYNC_EN undefined: written values SHALL take effect on the clock after the write; no shadow registers.

Verification
REQ-032 Release reset with default parameters -> pixel_tick every 4 clocks; hsync period 800 pixel_ticks, low for 96; vsync period 525 lines, low for 2.
REQ-033 Set layer_on=6'b000110, layer 1 rgb=8'hE0, layer 2 rgb=8'h1C, in the visible region -> RGB=8'hE0 one pixel_tick later.
REQ-034 Write 8'h02 to port 8'h42 and 8'h02 to port 8'h41 -> the layer 1 colour appears only while blink_fast=1; otherwise layer 2 or bg_color appears.
REQ-035 Write 8'h03 to port 8'h43 with no eligible layer -> RGB=8'h03 in the visible region; RGB=0 during blanking.
REQ-036 With VGA_COMP_FRAME_SYNC_EN defined, write layer_en=0 mid-frame -> compositing is unchanged until the next frame_start and RGB=bg_color afterwards; with the macro undefined, RGB changes on the next pixel_tick.
REQ-037 Assert reset mid-line -> RGB=0, hsync=vsync=1 and pixel_x=pixel_y=0 without waiting for a clock edge.
